// File: rtl/aes_core_ctrl.sv
// ----------------------------------------------------------------------------
// aes_core_ctrl
//
// Purpose:
//   Sequences an iterative AES round engine between the MM2S and S2MM
//   AXI-Stream paths of axi_aes. It collects a 5-word command from the MM2S
//   control stream (word 0 = mode, words 1..4 = 128-bit key, MSW first),
//   requests key expansion, then feeds one 128-bit MM2S beat per engine run
//   and returns each result on S2MM. A tlast handshake on S2MM closes the
//   frame, pulses aes_s2mm_eof_wr and returns to IDLE for a new command.
//
// Optional feature (compile-time macro):
//   AES_CTRL_TIMEOUT_EN - 8-bit watchdog in KEXP and RUN. On reaching
//                         C_TIMEOUT it sets ctrl_err and either moves on to
//                         BWAIT (KEXP) or emits a zero block (RUN).
//
// Ports:
//   m_axi_mm2s_aclk           in   sole clock
//   axi_reset                 in   synchronous, active-high reset
//   m_axis_mm2s_cntrl_*       in/out  command word stream (tdata/tvalid/tlast/tready)
//   m_axis_mm2s_*             in/out  input block stream (tdata/tkeep/tvalid/tlast/tready)
//   s_axis_s2mm_*             out/in  result block stream (tdata/tkeep/tvalid/tlast/tready)
//   core_key, core_decrypt    out  key and direction to the engine
//   core_key_load             out  1-cycle pulse: start key expansion
//   core_key_ready            in   level: key expansion complete
//   core_din, core_start      out  block and 1-cycle start pulse to the engine
//   core_dout, core_done      in   engine result, valid during the done pulse
//   aes_s2mm_eof_wr           out  1-cycle pulse per S2MM tlast handshake
//   ctrl_busy                 out  high in every state except IDLE
//   ctrl_err                  out  sticky error, cleared by reset only
//   ctrl_blk_cnt              out  blocks completed since reset (wraps)
// ----------------------------------------------------------------------------
module aes_core_ctrl #(
    parameter int C_M_AXIS_MM2S_TDATA_WIDTH       = 128,
    parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
    parameter int C_TIMEOUT                       = 255
) (
    input  logic                                       m_axi_mm2s_aclk,
    input  logic                                       axi_reset,
    // control (command) stream
    input  logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH-1:0] m_axis_mm2s_cntrl_tdata,
    input  logic                                       m_axis_mm2s_cntrl_tvalid,
    input  logic                                       m_axis_mm2s_cntrl_tlast,
    output logic                                       m_axis_mm2s_cntrl_tready,
    // input block stream
    input  logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]       m_axis_mm2s_tdata,
    input  logic [C_M_AXIS_MM2S_TDATA_WIDTH/8-1:0]     m_axis_mm2s_tkeep,
    input  logic                                       m_axis_mm2s_tvalid,
    input  logic                                       m_axis_mm2s_tlast,
    output logic                                       m_axis_mm2s_tready,
    // result block stream
    output logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]       s_axis_s2mm_tdata,
    output logic [C_M_AXIS_MM2S_TDATA_WIDTH/8-1:0]     s_axis_s2mm_tkeep,
    output logic                                       s_axis_s2mm_tvalid,
    output logic                                       s_axis_s2mm_tlast,
    input  logic                                       s_axis_s2mm_tready,
    // round engine
    output logic [127:0]                               core_key,
    output logic                                       core_decrypt,
    output logic                                       core_key_load,
    input  logic                                       core_key_ready,
    output logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]       core_din,
    output logic                                       core_start,
    input  logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]       core_dout,
    input  logic                                       core_done,
    // status
    output logic                                       aes_s2mm_eof_wr,
    output logic                                       ctrl_busy,
    output logic                                       ctrl_err,
    output logic [15:0]                                ctrl_blk_cnt
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (C_M_AXIS_MM2S_TDATA_WIDTH != 128) begin : g_bad_tdata_width
        $error("aes_core_ctrl: C_M_AXIS_MM2S_TDATA_WIDTH must be 128");
    end
    if (C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH != 32) begin : g_bad_cntrl_width
        $error("aes_core_ctrl: C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH must be 32");
    end
    if (C_TIMEOUT < 1 || C_TIMEOUT > 255) begin : g_bad_timeout
        $error("aes_core_ctrl: C_TIMEOUT must fit the 8-bit watchdog (1..255)");
    end

    localparam int DW = C_M_AXIS_MM2S_TDATA_WIDTH;
    localparam int KW = C_M_AXIS_MM2S_TDATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_KEXP  = 3'd3;
    localparam logic [2:0] S_BWAIT = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]    r_state;
    logic [2:0]    r_widx;          // index of the next command word in CMD
    logic [95:0]   r_key_sh;        // key words 1..3 staged until the command completes
    logic          r_cntrl_tready;
    logic          r_mm2s_tready;
    logic [DW-1:0] r_s2mm_tdata;
    logic [KW-1:0] r_s2mm_tkeep;
    logic          r_s2mm_tvalid;
    logic          r_s2mm_tlast;
    logic [127:0]  r_core_key;
    logic          r_decrypt;
    logic          r_key_load;
    logic [DW-1:0] r_core_din;
    logic          r_core_start;
    logic          r_eof;
    logic          r_busy;
    logic          r_err;
    logic [15:0]   r_blk_cnt;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic       w_cmd_hs;
    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_key_rdy;
    logic       w_tmo;
    logic [2:0] w_next;

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef AES_CTRL_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(C_TIMEOUT);

    logic [7:0] r_tmo;

    assign w_tmo = (r_tmo == TMO_LIMIT);

    // Counts cycles spent continuously in KEXP or RUN; any exit restarts it.
    always_ff @(posedge m_axi_mm2s_aclk) begin
        if (axi_reset) begin
            r_tmo <= '0;
        end else if ((r_state == S_KEXP || r_state == S_RUN) && (w_next == r_state)) begin
            r_tmo <= r_tmo + 8'd1;
        end else begin
            r_tmo <= '0;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_hs  = m_axis_mm2s_cntrl_tvalid & r_cntrl_tready;
        w_in_hs   = m_axis_mm2s_tvalid & r_mm2s_tready;
        w_out_hs  = r_s2mm_tvalid & s_axis_s2mm_tready;
        // key_ready is a level and may still show the previous key while the
        // load pulse is on the wire, so it is not trusted in that cycle.
        w_key_rdy = core_key_ready & ~r_key_load;
        w_next    = r_state;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_next = m_axis_mm2s_cntrl_tlast ? S_IDLE : S_CMD;
                end
            end
            S_CMD: begin
                if (w_cmd_hs) begin
                    if (m_axis_mm2s_cntrl_tlast) begin
                        w_next = (r_widx == 3'd4) ? S_KEXP : S_IDLE;
                    end else if (r_widx == 3'd4) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_cmd_hs && m_axis_mm2s_cntrl_tlast) begin
                    w_next = S_KEXP;
                end
            end
            S_KEXP: begin
                if (w_key_rdy || w_tmo) begin
                    w_next = S_BWAIT;
                end
            end
            S_BWAIT: begin
                if (w_in_hs) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (core_done || w_tmo) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (w_out_hs) begin
                    w_next = r_s2mm_tlast ? S_IDLE : S_BWAIT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge m_axi_mm2s_aclk) begin
        if (axi_reset) begin
            r_state        <= S_IDLE;
            r_widx         <= '0;
            r_key_sh       <= '0;
            r_cntrl_tready <= 1'b0;
            r_mm2s_tready  <= 1'b0;
            r_s2mm_tdata   <= '0;
            r_s2mm_tkeep   <= '0;
            r_s2mm_tvalid  <= 1'b0;
            r_s2mm_tlast   <= 1'b0;
            r_core_key     <= '0;
            r_decrypt      <= 1'b0;
            r_key_load     <= 1'b0;
            r_core_din     <= '0;
            r_core_start   <= 1'b0;
            r_eof          <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_blk_cnt      <= '0;
        end else begin
            r_state <= w_next;

            // Ready/busy flags follow the state being entered so they are
            // registered yet exact on the first cycle of each state.
            r_cntrl_tready <= (w_next == S_IDLE) || (w_next == S_CMD) || (w_next == S_DRAIN);
            r_mm2s_tready  <= (w_next == S_BWAIT);
            r_busy         <= (w_next != S_IDLE);

            r_key_load   <= 1'b0;
            r_core_start <= 1'b0;
            r_eof        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_decrypt <= m_axis_mm2s_cntrl_tdata[0];
                        r_widx    <= 3'd1;
                        if (m_axis_mm2s_cntrl_tlast) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (w_cmd_hs) begin
                        // The visible key is only replaced once word 4 arrives,
                        // so a truncated command leaves the old key intact.
                        case (r_widx)
                            3'd1:    r_key_sh[95:64] <= m_axis_mm2s_cntrl_tdata;
                            3'd2:    r_key_sh[63:32] <= m_axis_mm2s_cntrl_tdata;
                            3'd3:    r_key_sh[31:0]  <= m_axis_mm2s_cntrl_tdata;
                            3'd4:    r_core_key      <= {r_key_sh, m_axis_mm2s_cntrl_tdata};
                            default: ;
                        endcase
                        r_widx <= r_widx + 3'd1;
                        if (m_axis_mm2s_cntrl_tlast) begin
                            if (r_widx == 3'd4) begin
                                r_key_load <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Over-long command: the key is already committed and is used.
                    if (w_cmd_hs && m_axis_mm2s_cntrl_tlast) begin
                        r_err      <= 1'b1;
                        r_key_load <= 1'b1;
                    end
                end
                S_KEXP: begin
                    if (w_tmo && !w_key_rdy) begin
                        r_err <= 1'b1;
                    end
                end
                S_BWAIT: begin
                    if (w_in_hs) begin
                        r_core_din   <= m_axis_mm2s_tdata;
                        r_s2mm_tkeep <= m_axis_mm2s_tkeep;
                        r_s2mm_tlast <= m_axis_mm2s_tlast;
                        r_core_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        r_s2mm_tdata  <= core_dout;
                        r_s2mm_tvalid <= 1'b1;
                    end else if (w_tmo) begin
                        // Engine never answered: emit a zero block so the
                        // frame still closes with its original tlast.
                        r_s2mm_tdata  <= '0;
                        r_s2mm_tvalid <= 1'b1;
                        r_err         <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_out_hs) begin
                        r_s2mm_tvalid <= 1'b0;
                        r_blk_cnt     <= r_blk_cnt + 16'd1;
                        if (r_s2mm_tlast) begin
                            r_eof <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // An engine result with no block in flight is a protocol fault.
            if (core_done && (r_state != S_RUN)) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_axis_mm2s_cntrl_tready = r_cntrl_tready;
    assign m_axis_mm2s_tready       = r_mm2s_tready;
    assign s_axis_s2mm_tdata        = r_s2mm_tdata;
    assign s_axis_s2mm_tkeep        = r_s2mm_tkeep;
    assign s_axis_s2mm_tvalid       = r_s2mm_tvalid;
    assign s_axis_s2mm_tlast        = r_s2mm_tlast;
    assign core_key                 = r_core_key;
    assign core_decrypt             = r_decrypt;
    assign core_key_load            = r_key_load;
    assign core_din                 = r_core_din;
    assign core_start               = r_core_start;
    assign aes_s2mm_eof_wr          = r_eof;
    assign ctrl_busy                = r_busy;
    assign ctrl_err                 = r_err;
    assign ctrl_blk_cnt             = r_blk_cnt;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_core_ctrl
//
// Directed bench for aes_core_ctrl. A small behavioural engine answers
// core_key_load after 4 cycles and core_start after 10 cycles with
// core_dout = core_din ^ core_key. Inputs are driven and outputs sampled on
// the falling clock edge. Define AES_CTRL_TIMEOUT_EN to add the watchdog step.
// ----------------------------------------------------------------------------
module tb_aes_core_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         axi_reset = 1'b1;
    logic [31:0]  cn_tdata  = '0;
    logic         cn_tvalid = 1'b0;
    logic         cn_tlast  = 1'b0;
    logic         cn_tready;
    logic [127:0] mm_tdata  = '0;
    logic [15:0]  mm_tkeep  = '0;
    logic         mm_tvalid = 1'b0;
    logic         mm_tlast  = 1'b0;
    logic         mm_tready;
    logic [127:0] s2_tdata;
    logic [15:0]  s2_tkeep;
    logic         s2_tvalid;
    logic         s2_tlast;
    logic         s2_tready = 1'b1;
    logic [127:0] core_key;
    logic         core_decrypt;
    logic         core_key_load;
    logic         core_key_ready = 1'b0;
    logic [127:0] core_din;
    logic         core_start;
    logic [127:0] core_dout = '0;
    logic         core_done;
    logic         eof_wr;
    logic         ctrl_busy;
    logic         ctrl_err;
    logic [15:0]  ctrl_blk_cnt;

    aes_core_ctrl #(
        .C_M_AXIS_MM2S_TDATA_WIDTH       (128),
        .C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH (32),
        .C_TIMEOUT                       (255)
    ) dut (
        .m_axi_mm2s_aclk          (clk),
        .axi_reset                (axi_reset),
        .m_axis_mm2s_cntrl_tdata  (cn_tdata),
        .m_axis_mm2s_cntrl_tvalid (cn_tvalid),
        .m_axis_mm2s_cntrl_tlast  (cn_tlast),
        .m_axis_mm2s_cntrl_tready (cn_tready),
        .m_axis_mm2s_tdata        (mm_tdata),
        .m_axis_mm2s_tkeep        (mm_tkeep),
        .m_axis_mm2s_tvalid       (mm_tvalid),
        .m_axis_mm2s_tlast        (mm_tlast),
        .m_axis_mm2s_tready       (mm_tready),
        .s_axis_s2mm_tdata        (s2_tdata),
        .s_axis_s2mm_tkeep        (s2_tkeep),
        .s_axis_s2mm_tvalid       (s2_tvalid),
        .s_axis_s2mm_tlast        (s2_tlast),
        .s_axis_s2mm_tready       (s2_tready),
        .core_key                 (core_key),
        .core_decrypt             (core_decrypt),
        .core_key_load            (core_key_load),
        .core_key_ready           (core_key_ready),
        .core_din                 (core_din),
        .core_start               (core_start),
        .core_dout                (core_dout),
        .core_done                (core_done),
        .aes_s2mm_eof_wr          (eof_wr),
        .ctrl_busy                (ctrl_busy),
        .ctrl_err                 (ctrl_err),
        .ctrl_blk_cnt             (ctrl_blk_cnt)
    );

    // ---------------- behavioural round engine ----------------
    logic         eng_en   = 1'b1;
    logic         eng_done = 1'b0;
    logic         tb_done  = 1'b0;
    logic [127:0] eng_din  = '0;
    int           ecnt     = 0;
    int           kcnt     = 0;

    assign core_done = eng_done | tb_done;

    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (axi_reset) begin
            ecnt           <= 0;
            kcnt           <= 0;
            core_key_ready <= 1'b0;
        end else begin
            if (core_key_load) begin
                core_key_ready <= 1'b0;
                kcnt           <= 4;
            end else if (kcnt > 0) begin
                kcnt <= kcnt - 1;
                if (kcnt == 1) core_key_ready <= 1'b1;
            end
            if (core_start) begin
                ecnt    <= 10;
                eng_din <= core_din;
            end else if (ecnt > 0) begin
                ecnt <= ecnt - 1;
                if (ecnt == 1 && eng_en) begin
                    eng_done  <= 1'b1;
                    core_dout <= eng_din ^ core_key;
                end
            end
        end
    end

    // ---------------- event counters ----------------
    int n_kload = 0;
    int n_start = 0;
    int n_beat  = 0;
    int n_eof   = 0;

    always @(posedge clk) begin
        if (core_key_load)           n_kload <= n_kload + 1;
        if (core_start)              n_start <= n_start + 1;
        if (s2_tvalid && s2_tready)  n_beat  <= n_beat + 1;
        if (eof_wr)                  n_eof   <= n_eof + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [31:0] w, input logic last);
        int n;
        n         = 0;
        cn_tdata  = w;
        cn_tlast  = last;
        cn_tvalid = 1'b1;
        while (!cn_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_tready", 128'(cn_tready), 128'(1'b1));
        @(negedge clk);
        cn_tvalid = 1'b0;
        cn_tlast  = 1'b0;
    endtask

    task automatic send_key(input logic [127:0] k, input logic dec, input logic last4);
        send_cmd({31'd0, dec}, 1'b0);
        send_cmd(k[127:96], 1'b0);
        send_cmd(k[95:64], 1'b0);
        send_cmd(k[63:32], 1'b0);
        send_cmd(k[31:0], last4);
    endtask

    task automatic send_blk(input logic [127:0] d, input logic [15:0] keep, input logic last);
        int n;
        n         = 0;
        mm_tdata  = d;
        mm_tkeep  = keep;
        mm_tlast  = last;
        mm_tvalid = 1'b1;
        while (!mm_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("blk_tready", 128'(mm_tready), 128'(1'b1));
        @(negedge clk);
        mm_tvalid = 1'b0;
        mm_tlast  = 1'b0;
    endtask

    // Counts clock edges after the MM2S handshake until S2MM tvalid shows.
    task automatic wait_out(input int lim, output int lat);
        lat = 0;
        while (!s2_tvalid && lat < lim) begin
            @(negedge clk);
            lat++;
        end
        chk("out_tvalid", 128'(s2_tvalid), 128'(1'b1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        axi_reset = 1'b1;
        tick(2);
        axi_reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [127:0] k1, k2, k3;
    logic [127:0] blk  [0:2];
    logic [15:0]  keep [0:2];
    logic [127:0] d0;
    logic         l0;
    int           lat;
    int           bad;
    int           s_kload, s_start, s_beat, s_eof;

    initial begin
        k1      = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        k2      = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        k3      = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        blk[0]  = 128'h3243f6a8_885a308d_313198a2_e0370734;
        blk[1]  = 128'h00112233_44556677_8899aabb_ccddeeff;
        blk[2]  = 128'hffeeddcc_bbaa9988_77665544_33221100;
        keep[0] = 16'hffff;
        keep[1] = 16'h00ff;
        keep[2] = 16'h0f0f;

        // ---- reset state ----
        tick(3);
        chk("rst_tdata",   s2_tdata, '0);
        chk("rst_key",     core_key, '0);
        chk("rst_din",     core_din, '0);
        chk("rst_flags",   128'({cn_tready, mm_tready, s2_tvalid, s2_tlast, core_decrypt,
                                 core_key_load, core_start, eof_wr, ctrl_busy, ctrl_err}), '0);
        chk("rst_cnt",     128'({s2_tkeep, ctrl_blk_cnt}), '0);
        axi_reset = 1'b0;
        @(negedge clk);
        chk("idle_tready", 128'(cn_tready), 128'(1'b1));
        chk("idle_busy",   128'(ctrl_busy), 128'(1'b0));

        // ---- command {1, K0..K3}, tlast on K3 ----
        s_kload = n_kload;
        send_key(k1, 1'b1, 1'b1);
        chk("cmd_key",     core_key, k1);
        chk("cmd_decrypt", 128'(core_decrypt), 128'(1'b1));
        chk("cmd_busy",    128'(ctrl_busy), 128'(1'b1));
        tick(2);
        chk("cmd_kload_n", 128'(n_kload - s_kload), 128'(1));
        chk("cmd_err",     128'(ctrl_err), 128'(1'b0));

        // ---- 3-block frame, S2MM always ready ----
        s_start = n_start;
        s_beat  = n_beat;
        s_eof   = n_eof;
        for (int i = 0; i < 3; i++) begin
            send_blk(blk[i], keep[i], (i == 2));
            wait_out(100, lat);
            if (i == 0) chk("latency", 128'(lat), 128'(12));
            chk("frm_tdata", s2_tdata, blk[i] ^ k1);
            chk("frm_tlast", 128'(s2_tlast), 128'(i == 2));
            chk("frm_tkeep", 128'(s2_tkeep), 128'(keep[i]));
            tick(1);
        end
        tick(1);
        chk("frm_starts",  128'(n_start - s_start), 128'(3));
        chk("frm_beats",   128'(n_beat - s_beat), 128'(3));
        chk("frm_eof",     128'(n_eof - s_eof), 128'(1));
        chk("frm_blk_cnt", 128'(ctrl_blk_cnt), 128'(16'd3));
        chk("frm_idle",    128'(ctrl_busy), 128'(1'b0));
        chk("frm_err",     128'(ctrl_err), 128'(1'b0));

        // ---- S2MM back-pressure for 20 cycles in OUT ----
        send_key(k2, 1'b0, 1'b1);
        chk("bp_decrypt", 128'(core_decrypt), 128'(1'b0));
        s_eof     = n_eof;
        s2_tready = 1'b0;
        send_blk(blk[1], keep[1], 1'b0);
        wait_out(100, lat);
        d0 = s2_tdata;
        l0 = s2_tlast;
        chk("bp_tdata", d0, blk[1] ^ k2);
        s_beat    = n_beat;
        mm_tdata  = blk[2];
        mm_tkeep  = keep[2];
        mm_tlast  = 1'b1;
        mm_tvalid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (s2_tdata !== d0 || s2_tlast !== l0 || s2_tkeep !== keep[1] ||
                s2_tvalid !== 1'b1 || mm_tready !== 1'b0 || eof_wr !== 1'b0) bad++;
        end
        chk("bp_hold_bad", 128'(bad), 128'(0));
        chk("bp_no_beat",  128'(n_beat - s_beat), 128'(0));
        chk("bp_no_eof",   128'(n_eof - s_eof), 128'(0));
        s2_tready = 1'b1;
        send_blk(blk[2], keep[2], 1'b1);
        wait_out(100, lat);
        chk("bp2_tdata", s2_tdata, blk[2] ^ k2);
        chk("bp2_tlast", 128'(s2_tlast), 128'(1'b1));
        tick(2);
        chk("bp_eof",     128'(n_eof - s_eof), 128'(1));
        chk("bp_blk_cnt", 128'(ctrl_blk_cnt), 128'(16'd5));

        // ---- truncated command: tlast on word 2 ----
        s_kload = n_kload;
        send_cmd(32'h1, 1'b0);
        send_cmd(32'hdeadbeef, 1'b0);
        send_cmd(32'h01234567, 1'b1);
        tick(2);
        chk("trunc_err",   128'(ctrl_err), 128'(1'b1));
        chk("trunc_idle",  128'(ctrl_busy), 128'(1'b0));
        chk("trunc_kload", 128'(n_kload - s_kload), 128'(0));
        chk("trunc_key",   core_key, k2);
        chk("trunc_ready", 128'(cn_tready), 128'(1'b1));

        // ---- reset while a block is in RUN ----
        send_key(k3, 1'b1, 1'b1);
        send_blk(blk[0], keep[0], 1'b1);
        tick(3);
        chk("run_busy", 128'(ctrl_busy), 128'(1'b1));
        s_eof     = n_eof;
        axi_reset = 1'b1;
        @(negedge clk);
        chk("mrst_key",   core_key, '0);
        chk("mrst_din",   core_din, '0);
        chk("mrst_tdata", s2_tdata, '0);
        chk("mrst_flags", 128'({cn_tready, mm_tready, s2_tvalid, s2_tlast, core_decrypt,
                                core_key_load, core_start, eof_wr, ctrl_busy, ctrl_err}), '0);
        chk("mrst_cnt",   128'({s2_tkeep, ctrl_blk_cnt}), '0);
        axi_reset = 1'b0;
        tick(2);
        chk("mrst_idle",  128'(cn_tready), 128'(1'b1));
        chk("mrst_noeof", 128'(n_eof - s_eof), 128'(0));

        // ---- core_done outside RUN ----
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        @(negedge clk);
        chk("spur_err", 128'(ctrl_err), 128'(1'b1));
        do_reset();
        chk("spur_clr", 128'(ctrl_err), 128'(1'b0));

        // ---- over-long command: drained, key still used ----
        s_kload = n_kload;
        s_eof   = n_eof;
        send_key(k3, 1'b1, 1'b0);
        tick(1);
        chk("drain_nokload", 128'(n_kload - s_kload), 128'(0));
        send_cmd(32'h55555555, 1'b0);
        send_cmd(32'haaaaaaaa, 1'b1);
        tick(2);
        chk("drain_err",   128'(ctrl_err), 128'(1'b1));
        chk("drain_kload", 128'(n_kload - s_kload), 128'(1));
        chk("drain_key",   core_key, k3);
        send_blk(blk[2], keep[2], 1'b1);
        wait_out(100, lat);
        chk("drain_tdata", s2_tdata, blk[2] ^ k3);
        chk("drain_tkeep", 128'(s2_tkeep), 128'(16'h0f0f));
        tick(2);
        chk("drain_cnt",   128'(ctrl_blk_cnt), 128'(16'd1));
        chk("drain_eof",   128'(n_eof - s_eof), 128'(1));

`ifdef AES_CTRL_TIMEOUT_EN
        // ---- engine never answers ----
        do_reset();
        send_key(k1, 1'b0, 1'b1);
        eng_en = 1'b0;
        s_eof  = n_eof;
        send_blk(blk[0], keep[0], 1'b1);
        wait_out(600, lat);
        chk("tmo_tdata", s2_tdata, '0);
        chk("tmo_err",   128'(ctrl_err), 128'(1'b1));
        chk("tmo_tlast", 128'(s2_tlast), 128'(1'b1));
        tick(2);
        chk("tmo_eof",   128'(n_eof - s_eof), 128'(1));
        eng_en = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
